// File: rtl/wb_stream_writer_master_if.sv
// Stream-sink and Wishbone write-master signal bundle for wb_stream_writer_master.
// The master modport is the writer's view; slave is the stream source / bus target side.
interface wb_stream_writer_master_if #(
  parameter int unsigned WB_AW = 32,
  parameter int unsigned WB_DW = 32
);
  logic [WB_DW-1:0]   stream_data;
  logic               stream_valid;
  logic               stream_ready;
  logic [WB_AW-1:0]   wbm_adr;
  logic [WB_DW-1:0]   wbm_dat_w;
  logic [WB_DW/8-1:0] wbm_sel;
  logic               wbm_we;
  logic               wbm_cyc;
  logic               wbm_stb;
  logic [2:0]         wbm_cti;
  logic [1:0]         wbm_bte;
  logic [WB_DW-1:0]   wbm_dat_r;
  logic               wbm_ack;
  logic               wbm_err;

  modport master (
    input  stream_data, stream_valid, wbm_dat_r, wbm_ack, wbm_err,
    output stream_ready, wbm_adr, wbm_dat_w, wbm_sel, wbm_we, wbm_cyc, wbm_stb, wbm_cti,
           wbm_bte
  );

  modport slave (
    output stream_data, stream_valid, wbm_dat_r, wbm_ack, wbm_err,
    input  stream_ready, wbm_adr, wbm_dat_w, wbm_sel, wbm_we, wbm_cyc, wbm_stb, wbm_cti,
           wbm_bte
  );
endinterface

// File: rtl/wb_stream_writer_master.sv
// Stream-to-Wishbone writer: FIFO sink drained into a circular buffer as incrementing bursts.
// Define WB_STREAM_WRITER_CLASSIC_EN for classic single writes with an idle cycle between beats.
module wb_stream_writer_master #(
  parameter int unsigned WB_AW   = 32,
  parameter int unsigned WB_DW   = 32,
  parameter int unsigned FIFO_AW = 5
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  wb_stream_writer_master_if.master bus,
  input  logic                      enable,
  input  logic [WB_AW-1:0]          start_adr,
  input  logic [WB_AW-1:0]          buf_size,
  input  logic [WB_AW-1:0]          burst_size,
  output logic                      busy_o,
  output logic                      irq_o,
  output logic                      err_o
);
  localparam int unsigned Depth    = 2 ** FIFO_AW;
  localparam int unsigned AdrShift = $clog2(WB_DW / 8);

  typedef enum logic [1:0] {StIdle, StBurst, StError} state_e;
  state_e state_q, state_d;

  logic [WB_DW-1:0]   mem [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   fill_q;
  logic [WB_AW-1:0]   offset_q, offset_d, base_q, base_d, size_q, size_d;
  logic [WB_AW-1:0]   blen_q, blen_d, beat_q, beat_d;
  logic               irq_q, irq_d;
  logic               active, push, pop, ack, err_hit, last;
  logic [WB_AW-1:0]   cur_off, remain, want, blen_eff, fill_ext;

  assign push     = bus.stream_valid && !fill_q[FIFO_AW];
  assign ack      = active && bus.wbm_ack && !bus.wbm_err;
  assign err_hit  = active && bus.wbm_err;
  assign pop      = ack;
  assign last     = (beat_q == blen_q - 1'b1);
  assign fill_ext = WB_AW'(fill_q);

  // A stale offset beyond a shrunken buffer restarts from the base.
  assign cur_off  = (offset_q >= buf_size) ? '0 : offset_q;
  assign remain   = buf_size - cur_off;
  assign want     = (burst_size == '0) ? WB_AW'(1) : burst_size;
  assign blen_eff = (want < remain) ? want : remain;

`ifdef WB_STREAM_WRITER_CLASSIC_EN
  logic gap_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) gap_q <= 1'b0;
    else          gap_q <= ack && !last;
  end

  assign active      = (state_q == StBurst) && !gap_q;
  assign bus.wbm_cti = 3'b000;
`else
  assign active      = (state_q == StBurst);
  assign bus.wbm_cti = active ? (last ? 3'b111 : 3'b010) : 3'b000;
`endif

  assign bus.stream_ready = !fill_q[FIFO_AW];
  assign bus.wbm_cyc      = active;
  assign bus.wbm_stb      = active;
  assign bus.wbm_we       = active;
  assign bus.wbm_sel      = active ? '1 : '0;
  assign bus.wbm_bte      = 2'b00;
  assign bus.wbm_adr      = active ? base_q + (offset_q << AdrShift) : '0;
  assign bus.wbm_dat_w    = active ? mem[rd_ptr_q] : '0;
  assign busy_o           = (state_q == StBurst);
  assign err_o            = (state_q == StError);
  assign irq_o            = irq_q;

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    base_d   = base_q;
    size_d   = size_q;
    blen_d   = blen_q;
    beat_d   = beat_q;
    irq_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!enable) begin
          offset_d = '0;
        end else if (buf_size != '0 && fill_ext >= blen_eff) begin
          state_d  = StBurst;
          offset_d = cur_off;
          base_d   = start_adr;
          size_d   = buf_size;
          blen_d   = blen_eff;
          beat_d   = '0;
        end
      end
      StBurst: begin
        if (err_hit) begin
          state_d = StError;
        end else if (ack) begin
          beat_d = beat_q + 1'b1;
          if (offset_q + 1'b1 == size_q) begin
            offset_d = '0;
            irq_d    = 1'b1;
          end else begin
            offset_d = offset_q + 1'b1;
          end
          if (last) state_d = StIdle;
        end
      end
      StError: begin
        if (!enable) begin
          state_d  = StIdle;
          offset_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr_q] <= bus.stream_data;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      offset_q <= '0;
      base_q   <= '0;
      size_q   <= '0;
      blen_q   <= '0;
      beat_q   <= '0;
      irq_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      base_q   <= base_d;
      size_q   <= size_d;
      blen_q   <= blen_d;
      beat_q   <= beat_d;
      irq_q    <= irq_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end
endmodule
